// File: rtl/dmx_frame_writer.sv
// DMX512 transmitter: BREAK, MAB, start code, then NUM_SLOTS slots fetched one element ahead of use.
// Line output is combinational from state/shifter; there is no backpressure and the responder must answer within 1 cycle.
module dmx_frame_writer #(
    parameter int CLKS_PER_BIT = 108,
    parameter int NUM_SLOTS    = 6,
    parameter int BREAK_BITS   = 25,
    parameter int MAB_BITS     = 3,
    parameter int IFG_BITS     = 2,
    parameter int COLOR_SLOT   = 3,
    parameter int COLOR_VAL    = 120,
    parameter int DIMMER_SLOT  = 5,
    parameter int DIMMER_VAL   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] addr_in,
    input  logic [7:0] data_in,
    output logic [8:0] request_addr,
    output logic       request_pulse,
    output logic       dmx_tx,
    output logic       busy,
    output logic       frame_start,
    output logic       addr_err
);

    typedef enum logic [2:0] {S_IDLE, S_BREAK, S_MAB, S_SLOT, S_GAP} state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_nxt;
    logic [15:0] bit_cnt, bit_idx, elem_last;
    logic        bit_end, elem_end, first_cyc, last_slot;
    logic [8:0]  slot_idx, req_k;
    logic [10:0] shreg;
    logic [7:0]  next_byte;
    logic        cap_stb;

    always_comb begin
        elem_last = 16'd0;
        case (state)
            S_BREAK: elem_last = 16'(BREAK_BITS - 1);
            S_MAB:   elem_last = 16'(MAB_BITS - 1);
            S_SLOT:  elem_last = 16'd10;
            S_GAP:   elem_last = 16'(IFG_BITS - 1);
            default: elem_last = 16'd0;
        endcase
    end

    assign bit_end   = (bit_cnt == BIT_LAST);
    assign elem_end  = bit_end && (bit_idx == elem_last);
    assign first_cyc = (bit_cnt == 16'd0) && (bit_idx == 16'd0);
    assign last_slot = (slot_idx == 9'(NUM_SLOTS));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable) state_nxt = S_BREAK;
            S_BREAK: if (elem_end) state_nxt = S_MAB;
            S_MAB:   if (elem_end) state_nxt = S_SLOT;
            S_SLOT:  if (elem_end && last_slot) state_nxt = S_GAP;
            S_GAP:   if (elem_end) state_nxt = enable ? S_BREAK : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Slot 0 (start code) issues no fetch: slot 1 was already fetched during MAB.
    always_comb begin
        dmx_tx        = 1'b1;
        busy          = (state != S_IDLE);
        frame_start   = (state == S_BREAK) && first_cyc;
        request_pulse = first_cyc && ((state == S_MAB) ||
                        ((state == S_SLOT) && (slot_idx != 9'd0) && !last_slot));
        case (state)
            S_BREAK: dmx_tx = 1'b0;
            S_SLOT:  dmx_tx = shreg[0];
            default: dmx_tx = 1'b1;
        endcase
    end

    assign request_addr = req_k;

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= 16'd0;
            bit_idx   <= 16'd0;
            slot_idx  <= 9'd0;
            req_k     <= 9'd0;
            shreg     <= '1;
            next_byte <= 8'd0;
            cap_stb   <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                bit_cnt <= 16'd0;
                bit_idx <= 16'd0;
            end else if (bit_end) begin
                bit_cnt <= 16'd0;
                bit_idx <= elem_end ? 16'd0 : bit_idx + 16'd1;
            end else begin
                bit_cnt <= bit_cnt + 16'd1;
            end

            if (state == S_BREAK && elem_end)
                req_k <= 9'd1;

            if (state == S_MAB && elem_end) begin
                slot_idx <= 9'd0;
                shreg    <= {2'b11, 8'h00, 1'b0};
            end else if (state == S_SLOT) begin
                if (elem_end && !last_slot) begin
                    slot_idx <= slot_idx + 9'd1;
                    shreg    <= {2'b11, next_byte, 1'b0};
                    if (slot_idx + 9'd1 != 9'(NUM_SLOTS))
                        req_k <= slot_idx + 9'd2;
                end else if (bit_end) begin
                    shreg <= {1'b1, shreg[10:1]};
                end
            end

            // Responder answers one cycle after the strobe; its echo is sampled on the following edge.
            cap_stb  <= request_pulse;
            addr_err <= 1'b0;
            if (cap_stb) begin
                if (req_k == 9'(COLOR_SLOT))
                    next_byte <= 8'(COLOR_VAL);
                else if (req_k == 9'(DIMMER_SLOT))
                    next_byte <= 8'(DIMMER_VAL);
                else if (addr_in == req_k)
                    next_byte <= data_in;
                else begin
                    next_byte <= 8'h00;
                    addr_err  <= 1'b1;
                end
            end
        end
    end

endmodule
